// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB/I2C responder.
// Holds the controller state encoding, the default 7-bit device address,
// the position of the R/W bit in the address byte and the bus ACK/NACK levels.
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        WDATA,
        READ,
        WAIT_STOP
    } sccbState_t;

    localparam logic [6:0] DEFAULT_DEVICE_ADDRESS = 7'h21;
    localparam int         RW_BIT                 = 0;
    localparam logic       ACK                    = 1'b0;
    localparam logic       NACK                   = 1'b1;

endpackage

// File: rtl/sccb_line_sync.sv
// Input conditioning for the SCL/SDA pins.
// Synchronizes both pins into the systemClock domain and derives single-cycle
// edge pulses plus START/STOP bus conditions.
// Ports:
//   systemClock, nReset   clock and asynchronous active-low reset
//   sclIn, sdaIn          raw pin levels (asynchronous)
//   sdaS                  synchronized SDA level
//   sclRise, sclFall      one-cycle SCL edge pulses
//   start, stop           one-cycle START (SDA fall, SCL high) / STOP (SDA rise, SCL high)
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic systemClock,
    input  logic nReset,
    input  logic sclIn,
    input  logic sdaIn,
    output logic sdaS,
    output logic sclRise,
    output logic sclFall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] sclChain;
    logic [SYNC_STAGES-1:0] sdaChain;
    logic                   sclS;
    logic                   sclD;
    logic                   sdaD;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
    always_ff @(posedge systemClock or negedge nReset) begin
        if (!nReset) begin
            sclChain <= '1;
            sdaChain <= '1;
            sclD     <= 1'b1;
            sdaD     <= 1'b1;
        end else begin
            sclChain <= {sclChain[SYNC_STAGES-2:0], sclIn};
            sdaChain <= {sdaChain[SYNC_STAGES-2:0], sdaIn};
            sclD     <= sclS;
            sdaD     <= sdaS;
        end
    end

    assign sclS    = sclChain[SYNC_STAGES-1];
    assign sdaS    = sdaChain[SYNC_STAGES-1];
    assign sclRise = sclS & ~sclD;
    assign sclFall = ~sclS & sclD;
    assign start   = sclS & sdaD & ~sdaS;
    assign stop    = sclS & ~sdaD & sdaS;

endmodule

// File: rtl/sccb_responder.sv
// SCCB/I2C target exposing an 8-bit-addressed register file.
// Ports:
//   systemClock, nReset   clock (>= 16x SCL) and asynchronous active-low reset
//   sclIn, sdaIn          bus pin levels
//   sdaDriven             1 = pull SDA low (open drain handled at top level)
//   regAddress            register pointer
//   regWriteData, regWe   write data and its one-cycle strobe
//   regReadData           contents of regAddress (valid within 2 cycles)
//   busy                  device addressed (address ACK until STOP/START/NACK)
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the address byte
// ADDR_ACK  | acknowledging our address, then branching on R/W
// PTR       | receiving the register pointer byte (+ ACK)
// WDATA     | receiving write bytes (+ ACK, strobe, pointer increment)
// READ      | sending read bytes, sampling master ACK/NACK
// WAIT_STOP | not for us / finished, ignore bus until START or STOP
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDRESS = DEFAULT_DEVICE_ADDRESS,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic       systemClock,
    input  logic       nReset,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sdaDriven,
    output logic [7:0] regAddress,
    output logic [7:0] regWriteData,
    output logic       regWe,
    input  logic [7:0] regReadData,
    output logic       busy
);

    logic sdaS, sclRise, sclFall, start, stop;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uLineSync (
        .systemClock(systemClock),
        .nReset     (nReset),
        .sclIn      (sclIn),
        .sdaIn      (sdaIn),
        .sdaS       (sdaS),
        .sclRise    (sclRise),
        .sclFall    (sclFall),
        .start      (start),
        .stop       (stop)
    );

    sccbState_t state, stateNext;
    logic [3:0] bitCnt, bitCntNext;
    logic [7:0] shift, shiftNext;
    logic       ackOn, ackOnNext;
    logic       sdaDrivenNext, busyNext, regWeNext;
    logic [7:0] regAddressNext, regWriteDataNext;
    logic [7:0] rxByte;
    logic [2:0] txIndex;

    assign rxByte  = {shift[6:0], sdaS};
    assign txIndex = 3'd7 - bitCnt[2:0];

    always_ff @(posedge systemClock or negedge nReset) begin
        if (!nReset) begin
            state        <= IDLE;
            bitCnt       <= '0;
            shift        <= '0;
            ackOn        <= 1'b0;
            sdaDriven    <= 1'b0;
            busy         <= 1'b0;
            regWe        <= 1'b0;
            regAddress   <= '0;
            regWriteData <= '0;
        end else begin
            state        <= stateNext;
            bitCnt       <= bitCntNext;
            shift        <= shiftNext;
            ackOn        <= ackOnNext;
            sdaDriven    <= sdaDrivenNext;
            busy         <= busyNext;
            regWe        <= regWeNext;
            regAddress   <= regAddressNext;
            regWriteData <= regWriteDataNext;
        end
    end

    always_comb begin
        stateNext        = state;
        bitCntNext       = bitCnt;
        shiftNext        = shift;
        ackOnNext        = ackOn;
        sdaDrivenNext    = sdaDriven;
        busyNext         = busy;
        regWeNext        = 1'b0;
        regAddressNext   = regAddress;
        regWriteDataNext = regWriteData;

        if (stop) begin
            stateNext     = IDLE;
            bitCntNext    = '0;
            ackOnNext     = 1'b0;
            sdaDrivenNext = 1'b0;
            busyNext      = 1'b0;
        end else if (start) begin
            stateNext     = ADDR;
            bitCntNext    = '0;
            ackOnNext     = 1'b0;
            sdaDrivenNext = 1'b0;
            busyNext      = 1'b0;
        end else begin
            case (state)
                IDLE, WAIT_STOP: begin
                    sdaDrivenNext = 1'b0;
                end
                ADDR: begin
                    if (sclRise) begin
                        shiftNext  = rxByte;
                        bitCntNext = bitCnt + 4'd1;
                        if (bitCnt == 4'd7)
                            stateNext = (rxByte[7:1] == DEVICE_ADDRESS) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                ADDR_ACK: begin
                    // First fall: drive ACK. Second fall: release, branch on R/W
                    // kept in shift[RW_BIT].
                    if (sclFall) begin
                        if (!ackOn) begin
                            ackOnNext     = 1'b1;
                            sdaDrivenNext = 1'b1;
                            busyNext      = 1'b1;
                        end else begin
                            ackOnNext  = 1'b0;
                            bitCntNext = '0;
                            if (shift[RW_BIT]) begin
                                stateNext     = READ;
                                shiftNext     = regReadData;
                                sdaDrivenNext = ~regReadData[7];
                            end else begin
                                stateNext     = PTR;
                                sdaDrivenNext = 1'b0;
                            end
                        end
                    end
                end
                PTR, WDATA: begin
                    if (sclRise && bitCnt < 4'd8) begin
                        shiftNext  = rxByte;
                        bitCntNext = bitCnt + 4'd1;
                        if (bitCnt == 4'd7) begin
                            if (state == PTR) regAddressNext   = rxByte;
                            else              regWriteDataNext = rxByte;
                        end
                    end
                    if (sclFall && bitCnt == 4'd8) begin
                        if (!ackOn) begin
                            ackOnNext     = 1'b1;
                            sdaDrivenNext = 1'b1;
                            regWeNext     = (state == WDATA);
                        end else begin
                            ackOnNext     = 1'b0;
                            sdaDrivenNext = 1'b0;
                            bitCntNext    = '0;
                            stateNext     = WDATA;
                            if (state == WDATA) regAddressNext = regAddress + 8'd1;
                        end
                    end
                end
                READ: begin
                    // bitCnt counts SCL rises of the current byte; 9 means the
                    // master acked and a reload is due on the next fall.
                    if (sclRise && bitCnt < 4'd9) begin
                        bitCntNext = bitCnt + 4'd1;
                        if (bitCnt == 4'd8) begin
                            case (sdaS)
                                ACK:  regAddressNext = regAddress + 8'd1;
                                NACK: begin
                                    stateNext = WAIT_STOP;
                                    busyNext  = 1'b0;
                                end
                            endcase
                        end
                    end
                    if (sclFall) begin
                        if (bitCnt == 4'd9) begin
                            shiftNext     = regReadData;
                            sdaDrivenNext = ~regReadData[7];
                            bitCntNext    = '0;
                        end else if (bitCnt == 4'd8) begin
                            sdaDrivenNext = 1'b0;
                        end else if (bitCnt != 4'd0) begin
                            sdaDrivenNext = ~shift[txIndex];
                        end
                    end
                end
                default: begin
                    stateNext     = IDLE;
                    sdaDrivenNext = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: a bus-master model drives SCL/SDA
// (open drain resolved here), a transaction-level model predicts ACKs, register
// writes, read bytes and the pointer, and a per-cycle monitor checks strobes.
module tb_sccb_responder;
    import sccb_pkg::*;

    localparam int Q = 8;   // quarter SCL period in system clocks

    logic       systemClock = 1'b0;
    logic       nReset;
    logic       sclOut, sdaOut;
    logic       sclIn, sdaIn;
    logic       sdaDriven, regWe, busy;
    logic [7:0] regAddress, regWriteData, regReadData;

    always #5 systemClock = ~systemClock;

    assign sclIn       = sclOut;
    assign sdaIn       = sdaOut & ~sdaDriven;
    assign regReadData = regAddress + 8'h30;

    sccb_responder #(.DEVICE_ADDRESS(7'h21), .SYNC_STAGES(2)) dut (
        .systemClock (systemClock),
        .nReset      (nReset),
        .sclIn       (sclIn),
        .sdaIn       (sdaIn),
        .sdaDriven   (sdaDriven),
        .regAddress  (regAddress),
        .regWriteData(regWriteData),
        .regWe       (regWe),
        .regReadData (regReadData),
        .busy        (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  modelPtr = 8'h00;
    logic [15:0] expWrites[$];
    logic [7:0]  lastRead[$];
    bit          expectSilent = 1'b0;
    logic        sdaDrivenPrev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor.
    always @(negedge systemClock) begin
        if (nReset) begin
            if (regWe) begin
                if (expWrites.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL regWe_unexpected actual addr=0x%0h data=0x%0h required no write",
                             regAddress, regWriteData);
                end else begin
                    check("regWe_write", {regAddress, regWriteData}, expWrites.pop_front());
                end
            end
            if (sdaDriven !== sdaDrivenPrev)
                check("sda_change_only_scl_low", sclIn, 1'b0);
            if (expectSilent)
                check("foreign_silent", {sdaDriven, busy, regWe}, 3'b000);
        end
        sdaDrivenPrev = sdaDriven;
    end

    task automatic waitQ();
        repeat (Q) @(posedge systemClock);
        #1;
    endtask

    task automatic busStart();
        sdaOut = 1'b1; waitQ();
        sclOut = 1'b1; waitQ();
        sdaOut = 1'b0; waitQ();
        sclOut = 1'b0; waitQ();
    endtask

    task automatic busStop();
        sdaOut = 1'b0; waitQ();
        sclOut = 1'b1; waitQ();
        sdaOut = 1'b1; waitQ();
    endtask

    task automatic bitCycle(input logic b, output logic s);
        sdaOut = b;    waitQ();
        sclOut = 1'b1; waitQ();
        s = sdaIn;     waitQ();
        sclOut = 1'b0; waitQ();
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bitCycle(d[i], s);
        bitCycle(1'b1, ack);
    endtask

    task automatic recvByte(input logic masterAck, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bitCycle(1'b1, s);
            d[i] = s;
        end
        bitCycle(masterAck, s);
    endtask

    task automatic writeTxn(input logic [7:0] ptr, input logic [7:0] data[$]);
        logic ack;
        busStart();
        sendByte(8'h42, ack);
        check("addr_w_ack", ack, ACK);
        check("busy_after_addr", busy, 1'b1);
        sendByte(ptr, ack);
        check("ptr_ack", ack, ACK);
        modelPtr = ptr;
        foreach (data[i]) begin
            expWrites.push_back({modelPtr, data[i]});
            sendByte(data[i], ack);
            check("wdata_ack", ack, ACK);
            modelPtr = modelPtr + 8'd1;
        end
        busStop();
        check("write_ptr_after", regAddress, modelPtr);
        check("busy_after_stop", busy, 1'b0);
        check("writes_drained", expWrites.size(), 0);
        expWrites.delete();
    endtask

    task automatic readTxn(input logic [7:0] ptr, input int n);
        logic       ack;
        logic [7:0] d;
        lastRead.delete();
        busStart();
        sendByte(8'h42, ack);
        check("addr_w_ack", ack, ACK);
        sendByte(ptr, ack);
        check("ptr_ack", ack, ACK);
        modelPtr = ptr;
        busStart();
        sendByte(8'h43, ack);
        check("addr_r_ack", ack, ACK);
        for (int k = 0; k < n; k++) begin
            bit last;
            last = (k == n - 1);
            recvByte(last ? NACK : ACK, d);
            lastRead.push_back(d);
            check("read_data", d, modelPtr + 8'h30);
            if (!last) modelPtr = modelPtr + 8'd1;
            check("busy_in_read", busy, last ? 1'b0 : 1'b1);
            check("sda_released_ack_slot", sdaDriven, (!last && ((modelPtr + 8'h30) & 8'h80) == 0) ? 1'b1 : 1'b0);
        end
        busStop();
        check("read_ptr_after", regAddress, modelPtr);
        check("busy_after_stop", busy, 1'b0);
    endtask

    task automatic foreignTxn(input logic [6:0] addr, input logic rw, input int n);
        logic ack;
        expectSilent = 1'b1;
        busStart();
        sendByte({addr, rw}, ack);
        check("foreign_addr_nack", ack, NACK);
        for (int k = 0; k < n; k++) begin
            sendByte(8'($urandom), ack);
            check("foreign_byte_nack", ack, NACK);
        end
        busStop();
        expectSilent = 1'b0;
        check("foreign_ptr_unchanged", regAddress, modelPtr);
    endtask

    initial begin
        logic [7:0] dq[$];
        logic       ack, s;
        logic [3:0] nib;

        nReset = 1'b0;
        sclOut = 1'b1;
        sdaOut = 1'b1;
        repeat (3) @(posedge systemClock);
        #1;
        check("reset_outputs", {sdaDriven, regWe, busy, regAddress, regWriteData}, 19'd0);
        nReset = 1'b1;
        waitQ();

        // Single write: 0x42, 0x12, 0x80.
        dq.delete(); dq.push_back(8'h80);
        writeTxn(8'h12, dq);
        check("t1_ptr_literal", regAddress, 8'h13);
        check("t1_wdata_literal", regWriteData, 8'h80);

        // Pointer wrap: 0xFF <- 0xAA, 0x00 <- 0x55.
        dq.delete(); dq.push_back(8'hAA); dq.push_back(8'h55);
        writeTxn(8'hFF, dq);
        check("t2_ptr_wrap_literal", regAddress, 8'h01);

        // Pointer only, no data.
        dq.delete();
        writeTxn(8'h5C, dq);
        check("t_ptr_only_literal", regAddress, 8'h5C);

        // Read two bytes from 0x0A.
        readTxn(8'h0A, 2);
        check("t3_read0_literal", lastRead[0], 8'h3A);
        check("t3_read1_literal", lastRead[1], 8'h3B);
        check("t3_ptr_literal", regAddress, 8'h0B);

        // Different device (0x44 byte = 7'h22 write) with 3 bytes.
        foreignTxn(7'h22, 1'b0, 3);

        // STOP after 4 bits of a read byte from 0x08 (data 0x38).
        busStart();
        sendByte(8'h42, ack);
        sendByte(8'h08, ack);
        modelPtr = 8'h08;
        busStart();
        sendByte(8'h43, ack);
        check("t5_addr_r_ack", ack, ACK);
        for (int i = 3; i >= 0; i--) begin
            bitCycle(1'b1, s);
            nib[i] = s;
        end
        check("t5_partial_bits", nib, 4'h3);
        check("t5_busy_before_stop", busy, 1'b1);
        sdaOut = 1'b0; waitQ();
        sclOut = 1'b1; waitQ();
        sdaOut = 1'b1;
        repeat (4) @(posedge systemClock);
        #1;
        check("t5_sda_after_stop", sdaDriven, 1'b0);
        check("t5_busy_after_stop", busy, 1'b0);
        waitQ();
        dq.delete(); dq.push_back(8'hC3);
        writeTxn(8'h20, dq);
        check("t5_recovery_ptr", regAddress, 8'h21);

        // Reset while driving the address ACK.
        busStart();
        for (int i = 7; i >= 0; i--) bitCycle(((8'h42 >> i) & 1) != 0, s);
        sdaOut = 1'b1;
        waitQ();
        check("t6_ack_driven", sdaDriven, 1'b1);
        #2 nReset = 1'b0;
        #1;
        check("t6_async_sda_release", sdaDriven, 1'b0);
        check("t6_reset_outputs", {regWe, busy, regAddress, regWriteData}, 18'd0);
        sclOut = 1'b1;
        sdaOut = 1'b1;
        repeat (3) @(posedge systemClock);
        #1 nReset = 1'b1;
        modelPtr = 8'h00;
        waitQ();

        // Randomized transactions.
        for (int t = 0; t < 16; t++) begin
            int         kind;
            logic [6:0] fa;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                int n;
                n = $urandom_range(0, 3);
                dq.delete();
                for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
                writeTxn(8'($urandom), dq);
            end else if (kind == 1) begin
                readTxn(8'($urandom), $urandom_range(1, 3));
            end else begin
                fa = 7'($urandom_range(0, 127));
                if (fa == 7'h21) fa = 7'h22;
                foreignTxn(fa, 1'($urandom), $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
